// File: rtl/pattern_gen_if.sv
// pattern_gen_if: raster bundle into the pattern generator and pixel bundle out of it
//   sx, sy, de, hsync, vsync    : screen coordinates and syncs from the timing generator
//   rgb, de_o, hsync_o, vsync_o : pixel {R,G,B} and syncs delayed to stay aligned with it
interface pattern_gen_if #(
    parameter int CORDW = 10,
    parameter int BPC   = 8
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic [3*BPC-1:0] rgb;
    logic             de_o;
    logic             hsync_o;
    logic             vsync_o;
    modport master (output sx, sy, de, hsync, vsync, input rgb, de_o, hsync_o, vsync_o);
    modport slave  (input sx, sy, de, hsync, vsync, output rgb, de_o, hsync_o, vsync_o);
endinterface

// File: rtl/pattern_gen.sv
// pattern_gen: video test-pattern generator (sprite, bars, checker, gradient) with a 2-cycle pixel pipeline
//   clk_pix, rst_n : pixel clock, asynchronous active-low reset
//   vid            : raster in (sx, sy, de, hsync, vsync), pixel out (rgb, de_o, hsync_o, vsync_o)
//   mode           : 0 sprite, 1 bars, 2 checker, 3 gradient; takes effect at the frame tick
//   pause          : freezes sprite motion
//   frame          : frame counter
module pattern_gen #(
    parameter int CORDW    = 10,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int Q_SIZE   = 32,
    parameter int Q_SPEED  = 4,
    parameter int BPC      = 8
) (
    input  logic         clk_pix,
    input  logic         rst_n,
    pattern_gen_if.slave vid,
    input  logic [1:0]   mode,
    input  logic         pause,
    output logic [15:0]  frame
);
    localparam logic [CORDW:0] X_MAX = (CORDW+1)'(H_ACTIVE - Q_SIZE);
    localparam logic [CORDW:0] Y_MAX = (CORDW+1)'(V_ACTIVE - Q_SIZE);
    localparam logic [CORDW:0] SPD   = (CORDW+1)'(Q_SPEED);
    localparam logic [CORDW:0] QSZ   = (CORDW+1)'(Q_SIZE);

    // One sprite step on one axis; returns {dir, pos}, clamping at 0 and lim
    function automatic logic [CORDW:0] bounce(input logic [CORDW-1:0] p, input logic dir, input logic [CORDW:0] lim);
        return !dir ? (({1'b0, p} + SPD >= lim) ? {1'b1, lim[CORDW-1:0]} : {1'b0, p + SPD[CORDW-1:0]})
                    : (({1'b0, p} <= SPD) ? '0 : {1'b1, p - SPD[CORDW-1:0]});
    endfunction

    logic             tick;
    logic [15:0]      frame_q, frame_d;
    logic [1:0]       mode_q, mode_d;
    logic [CORDW-1:0] qx_q, qx_d, qy_q, qy_d;
    logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic             spr_q, spr_d, ck_q, ck_d;
    logic [2:0]       bar_q, bar_d;
    logic [23:0]      grad_q, grad_d;
    logic [1:0]       mode_s_q, mode_s_d;
    logic [2:0]       sync_s_q, sync_s_d;
    logic [3*BPC-1:0] rgb_q, rgb_d;
    logic [2:0]       sync_o_q, sync_o_d;
    logic [23:0]      v;
    logic [31:0]      sx8;

    always_comb begin
        tick = vid.sy == CORDW'(V_ACTIVE) && vid.sx == '0;
        frame_d = tick ? frame_q + 16'd1 : frame_q;
        mode_d = tick ? mode : mode_q;
        {dir_x_d, qx_d} = (tick && !pause) ? bounce(qx_q, dir_x_q, X_MAX) : {dir_x_q, qx_q};
        {dir_y_d, qy_d} = (tick && !pause) ? bounce(qy_q, dir_y_q, Y_MAX) : {dir_y_q, qy_q};
        // stage 1: pattern primitives from the raster position and frame-stable state
        spr_d = {1'b0, vid.sx} >= {1'b0, qx_q} && {1'b0, vid.sx} < {1'b0, qx_q} + QSZ &&
                {1'b0, vid.sy} >= {1'b0, qy_q} && {1'b0, vid.sy} < {1'b0, qy_q} + QSZ;
        // bar index = (sx*8)/H_ACTIVE, built from 7 threshold compares instead of a divider
        sx8 = 32'(vid.sx) << 3;
        bar_d = '0;
        for (int k = 1; k < 8; k++)
            bar_d = bar_d + 3'(sx8 >= 32'(k * H_ACTIVE));
        // bit 5 of (sx + frame) only depends on the low 6 bits of each
        ck_d = ((vid.sx[5:0] + frame_q[5:0]) >= 6'd32) ^ vid.sy[5];
        grad_d = {vid.sx[7:0], vid.sy[7:0], frame_q[7:0]};
        mode_s_d = mode_q;
        sync_s_d = {vid.de, vid.hsync, vid.vsync};
        // stage 2: final 8-bit colour, blanked on the delayed de, then truncated to BPC
        v = !sync_s_q[2] ? '0 :
            mode_s_q == 2'd0 ? {24{spr_q}} :
            mode_s_q == 2'd1 ? {{8{~bar_q[1]}}, {8{~bar_q[2]}}, {8{~bar_q[0]}}} :
            mode_s_q == 2'd2 ? {24{ck_q}} : grad_q;
        rgb_d = {v[23 -: BPC], v[15 -: BPC], v[7 -: BPC]};
        sync_o_d = sync_s_q;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            frame_q  <= '0;
            mode_q   <= '0;
            qx_q     <= '0;
            qy_q     <= '0;
            dir_x_q  <= 1'b0;
            dir_y_q  <= 1'b0;
            spr_q    <= 1'b0;
            ck_q     <= 1'b0;
            bar_q    <= '0;
            grad_q   <= '0;
            mode_s_q <= '0;
            sync_s_q <= '0;
            rgb_q    <= '0;
            sync_o_q <= '0;
        end else begin
            frame_q  <= frame_d;
            mode_q   <= mode_d;
            qx_q     <= qx_d;
            qy_q     <= qy_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            spr_q    <= spr_d;
            ck_q     <= ck_d;
            bar_q    <= bar_d;
            grad_q   <= grad_d;
            mode_s_q <= mode_s_d;
            sync_s_q <= sync_s_d;
            rgb_q    <= rgb_d;
            sync_o_q <= sync_o_d;
        end
    end

    assign frame = frame_q;
    assign vid.rgb = rgb_q;
    assign {vid.de_o, vid.hsync_o, vid.vsync_o} = sync_o_q;
endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: scoreboard and table-driven bench for pattern_gen at BPC 8 and BPC 4
module tb_pattern_gen;
    logic        clk_pix = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        pause = 1'b0;
    logic [15:0] frame8, frame4;

    always #5 clk_pix = ~clk_pix;

    pattern_gen_if #(.CORDW(10), .BPC(8)) v8 ();
    pattern_gen_if #(.CORDW(10), .BPC(4)) v4 ();

    assign v4.sx = v8.sx;
    assign v4.sy = v8.sy;
    assign v4.de = v8.de;
    assign v4.hsync = v8.hsync;
    assign v4.vsync = v8.vsync;

    pattern_gen #(.BPC(8)) dut (.clk_pix(clk_pix), .rst_n(rst_n), .vid(v8), .mode(mode), .pause(pause), .frame(frame8));
    pattern_gen #(.BPC(4)) dut4 (.clk_pix(clk_pix), .rst_n(rst_n), .vid(v4), .mode(mode), .pause(pause), .frame(frame4));

    typedef struct packed {
        logic        chk;
        logic [23:0] rgb8;
        logic [11:0] rgb4;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    typedef struct {
        int          g;
        int          sx;
        int          sy;
        bit          de;
        logic [23:0] rgb;
    } vec_t;

    exp_t sb[$];
    vec_t tab[$];
    int   n_chk = 0;
    int   n_fail = 0;

    int   m_frame, m_qx, m_qy;
    bit   m_dx, m_dy;
    logic [1:0] m_mode;

    function automatic logic [11:0] to4(logic [23:0] c);
        return {c[23:20], c[15:12], c[7:4]};
    endfunction

    function automatic logic [23:0] colour(int sx, int sy, bit de);
        if (!de) return 24'h0;
        case (m_mode)
            2'd0: return (sx >= m_qx && sx < m_qx + 32 && sy >= m_qy && sy < m_qy + 32) ? 24'hFFFFFF : 24'h0;
            2'd1: case ((sx * 8) / 640)
                0: return 24'hFFFFFF;
                1: return 24'hFFFF00;
                2: return 24'h00FFFF;
                3: return 24'h00FF00;
                4: return 24'hFF00FF;
                5: return 24'hFF0000;
                6: return 24'h0000FF;
                default: return 24'h000000;
            endcase
            2'd2: return ((((sx + m_frame % 256) / 32) % 2) != ((sy / 32) % 2)) ? 24'hFFFFFF : 24'h0;
            default: return {8'(sx % 256), 8'(sy % 256), 8'(m_frame % 256)};
        endcase
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_frame();
        check("frame8", 32'(frame8), 32'(m_frame));
        check("frame4", 32'(frame4), 32'(m_frame));
    endtask

    task automatic model_reset();
        m_frame = 0;
        m_mode = 2'd0;
        m_qx = 0;
        m_qy = 0;
        m_dx = 1'b0;
        m_dy = 1'b0;
    endtask

    task automatic model_tick();
        m_frame = (m_frame + 1) % 65536;
        m_mode = mode;
        if (!pause) begin
            if (!m_dx) begin
                if (m_qx + 4 >= 608) begin m_qx = 608; m_dx = 1'b1; end else m_qx += 4;
            end else if (m_qx <= 4) begin m_qx = 0; m_dx = 1'b0; end else m_qx -= 4;
            if (!m_dy) begin
                if (m_qy + 4 >= 448) begin m_qy = 448; m_dy = 1'b1; end else m_qy += 4;
            end else if (m_qy <= 4) begin m_qy = 0; m_dy = 1'b0; end else m_qy -= 4;
        end
    endtask

    // Drive one raster cycle, queue its expected output, compare the entry due two cycles later
    task automatic step(int sx, int sy, bit de, bit hs, bit vs, bit chk, logic [23:0] e8);
        exp_t e;
        v8.sx = 10'(sx);
        v8.sy = 10'(sy);
        v8.de = de;
        v8.hsync = hs;
        v8.vsync = vs;
        sb.push_back('{chk, e8, to4(e8), de, hs, vs});
        if (sx == 0 && sy == 480) model_tick();
        @(posedge clk_pix);
        #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            if (e.chk) begin
                check("rgb8", 32'(v8.rgb), 32'(e.rgb8));
                check("rgb4", 32'(v4.rgb), 32'(e.rgb4));
                check("de_o", 32'(v8.de_o), 32'(e.de));
                check("hsync_o", 32'(v8.hsync_o), 32'(e.hs));
                check("vsync_o", 32'(v8.vsync_o), 32'(e.vs));
            end
        end
    endtask

    task automatic px(int sx, int sy, bit de);
        step(sx, sy, de, de, 1'b0, 1'b1, colour(sx, sy, de));
    endtask

    task automatic do_tick(bit chk);
        step(0, 480, 1'b0, 1'b0, 1'b1, chk, 24'h0);
    endtask

    task automatic probe();
        px(m_qx, m_qy, 1'b1);
        px(m_qx + 31, m_qy + 31, 1'b1);
        px(m_qx + 32, m_qy, 1'b1);
        px(m_qx + 5, m_qy + 32, 1'b1);
        if (m_qx > 0) px(m_qx - 1, m_qy, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v8.sx = '0;
        v8.sy = '0;
        v8.de = 1'b0;
        v8.hsync = 1'b0;
        v8.vsync = 1'b0;
        repeat (2) @(posedge clk_pix);
        #1;
        rst_n = 1'b1;
        sb.delete();
        sb.push_back('{1'b1, 24'h0, 12'h0, 1'b0, 1'b0, 1'b0});
        model_reset();
    endtask

    task automatic add(int g, int sx, int sy, bit de, logic [23:0] rgb);
        tab.push_back('{g, sx, sy, de, rgb});
    endtask

    task automatic run_group(int g);
        foreach (tab[i])
            if (tab[i].g == g) step(tab[i].sx, tab[i].sy, tab[i].de, 1'b0, 1'b0, 1'b1, tab[i].rgb);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_rgb8"}, 32'(v8.rgb), 32'h0);
        check({tag, "_rgb4"}, 32'(v4.rgb), 32'h0);
        check({tag, "_de_o"}, 32'(v8.de_o), 32'h0);
        check({tag, "_hsync_o"}, 32'(v8.hsync_o), 32'h0);
        check({tag, "_vsync_o"}, 32'(v8.vsync_o), 32'h0);
        check({tag, "_frame8"}, 32'(frame8), 32'h0);
        check({tag, "_frame4"}, 32'(frame4), 32'h0);
    endtask

    initial begin
        int rx, ry;
        bit rd, rh, rv;
        // sprite at (4,4) after the first tick
        add(1, 4, 4, 1, 24'hFFFFFF);   add(1, 3, 4, 1, 24'h0);        add(1, 4, 3, 1, 24'h0);
        add(1, 35, 35, 1, 24'hFFFFFF); add(1, 36, 35, 1, 24'h0);      add(1, 35, 36, 1, 24'h0);
        // sprite at (576,256) after 160 ticks
        add(2, 576, 256, 1, 24'hFFFFFF); add(2, 575, 256, 1, 24'h0);  add(2, 607, 287, 1, 24'hFFFFFF);
        add(2, 608, 287, 1, 24'h0);      add(2, 576, 288, 1, 24'h0);  add(2, 600, 270, 0, 24'h0);
        // colour bars
        add(3, 0, 100, 1, 24'hFFFFFF);   add(3, 79, 100, 1, 24'hFFFFFF);  add(3, 80, 100, 1, 24'hFFFF00);
        add(3, 160, 100, 1, 24'h00FFFF); add(3, 240, 100, 1, 24'h00FF00); add(3, 320, 100, 1, 24'hFF00FF);
        add(3, 400, 100, 1, 24'hFF0000); add(3, 480, 100, 1, 24'h0000FF); add(3, 559, 100, 1, 24'h0000FF);
        add(3, 560, 100, 1, 24'h0);      add(3, 639, 100, 1, 24'h0);      add(3, 80, 100, 0, 24'h0);
        // gradient at frame 0xAC
        add(4, 5, 7, 1, 24'h0507AC);     add(4, 300, 479, 1, 24'h2CDFAC); add(4, 255, 200, 1, 24'hFFC8AC);
        add(4, 5, 7, 0, 24'h0);
        // checker at frame 1 (shifted left by one pixel)
        add(5, 31, 0, 1, 24'hFFFFFF);    add(5, 30, 0, 1, 24'h0);         add(5, 32, 0, 1, 24'hFFFFFF);
        add(5, 31, 32, 1, 24'h0);        add(5, 62, 0, 1, 24'hFFFFFF);    add(5, 63, 0, 1, 24'h0);
        add(5, 31, 0, 0, 24'h0);
        // checker at frame 0 after the counter wraps
        add(6, 32, 0, 1, 24'hFFFFFF);    add(6, 31, 0, 1, 24'h0);         add(6, 32, 32, 1, 24'h0);
        add(6, 0, 32, 1, 24'hFFFFFF);    add(6, 63, 0, 1, 24'hFFFFFF);    add(6, 64, 0, 1, 24'h0);
        add(6, 32, 0, 0, 24'h0);
        // sprite at (608,288) after 152 ticks, just turned around on X
        add(7, 608, 288, 1, 24'hFFFFFF); add(7, 607, 288, 1, 24'h0);      add(7, 639, 319, 1, 24'hFFFFFF);
        add(7, 639, 320, 1, 24'h0);

        do_reset();
        check_zero("reset");

        for (int i = 0; i < 40; i++) begin
            rx = (i < 10) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 639));
            ry = (i < 10) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 479));
            rd = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            step(rx, ry, rd, rh, rv, 1'b1, colour(rx, ry, rd));
        end

        do_tick(1'b1);
        check_frame();
        run_group(1);
        probe();
        repeat (151) begin
            do_tick(1'b1);
            probe();
        end
        check_frame();
        run_group(7);
        repeat (8) begin
            do_tick(1'b1);
            probe();
        end
        check_frame();
        run_group(2);

        pause = 1'b1;
        repeat (10) do_tick(1'b1);
        pause = 1'b0;
        check_frame();
        run_group(2);
        probe();

        mode = 2'd1;
        px(576, 256, 1'b1);
        px(80, 100, 1'b1);
        px(0, 0, 1'b1);
        do_tick(1'b1);
        run_group(3);

        mode = 2'd3;
        do_tick(1'b1);
        check_frame();
        run_group(4);
        px(123, 45, 1'b1);

        px(100, 50, 1'b1);
        px(101, 50, 1'b1);
        rst_n = 1'b0;
        #2;
        check_zero("async");
        do_reset();
        probe();

        mode = 2'd2;
        do_tick(1'b1);
        check_frame();
        run_group(5);

        repeat (65534) do_tick(1'b0);
        check_frame();
        check("frame_ffff", 32'(frame8), 32'h0000FFFF);
        do_tick(1'b1);
        check_frame();
        run_group(6);

        px(0, 0, 1'b0);
        px(0, 0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised video test-pattern generator driven by the display timing generator's screen coordinates. Produces registered RGB pixels in four selectable modes: bouncing sprite, colour bars, scrolling checkerboard and gradient. Delays `de`/`hsync`/`vsync` to match the pixel pipeline. Sits between the timing generator and the TMDS/HDMI encoder in the pixel clock domain.

## Interface
Parameters:
- CORDW, 10, coordinate width in bits
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- Q_SIZE, 32, sprite edge length in pixels (Q_SIZE < H_ACTIVE, Q_SIZE < V_ACTIVE)
- Q_SPEED, 4, sprite step per frame per axis (1 ≤ Q_SPEED ≤ Q_SIZE)
- BPC, 8, bits per colour channel (1..8)

Ports:
- clk_pix  in  1  pixel clock; the single clock of the block
- rst_n  in  1  asynchronous, active-low reset
- sx  in  CORDW  horizontal coordinate from the timing generator
- sy  in  CORDW  vertical coordinate from the timing generator
- de  in  1  data enable, aligned with sx/sy
- hsync  in  1  horizontal sync, aligned with sx/sy
- vsync  in  1  vertical sync, aligned with sx/sy
- mode  in  2  pattern select: 0 sprite, 1 bars, 2 checker, 3 gradient
- pause  in  1  freezes sprite motion while high
- rgb  out  3*BPC  pixel {R,G,B}
- de_o, hsync_o, vsync_o  out  1 each  delayed de/hsync/vsync
- frame  out  16  frame counter

## Operation
- Frame tick: internal single-cycle pulse when sy == V_ACTIVE && sx == 0.
- On tick:
  - `frame` increments, wrapping 0xFFFF→0, independent of `pause`.
  - `mode` is sampled into mode_q. Mode changes take effect only at frame boundaries. A `mode` change in the tick cycle itself is captured.
- Sprite state: qx, qy (CORDW), dir_x, dir_y (0 = increasing).
  - Updates only on tick with pause == 0.
  - X axis, dir_x == 0: if qx + Q_SPEED ≥ H_ACTIVE − Q_SIZE, then qx ← H_ACTIVE − Q_SIZE and dir_x ← 1; else qx ← qx + Q_SPEED.
  - X axis, dir_x == 1: if qx ≤ Q_SPEED, then qx ← 0 and dir_x ← 0; else qx ← qx − Q_SPEED.
  - Y axis: same rules with qy, dir_y and V_ACTIVE. Both axes update in the same tick.
  - Clamping means qx is never > H_ACTIVE − Q_SIZE and qy is never > V_ACTIVE − Q_SIZE.
  - Comparisons use CORDW+1 bits so there is no overflow.
- Colour per mode. Each value is an 8-bit intensity v; the output channel is v[7 -: BPC].
  - 0 sprite: white (FF,FF,FF) when qx ≤ sx < qx+Q_SIZE and qy ≤ sy < qy+Q_SIZE; else black.
  - 1 bars: index = (sx·8)/H_ACTIVE, giving 0..7. Order: white, yellow, cyan, green, magenta, red, blue, black. Fully saturated: FF/00 per channel.
  - 2 checker: white when ((sx + frame[7:0]) bit 5) XOR sy[5] is 1; else black. The pattern scrolls left by 1 pixel per frame.
  - 3 gradient: R = sx[7:0], G = sy[7:0], B = frame[7:0].
- Blanking: rgb = 0 whenever the delayed de is 0.

## Timing
- Latency is fixed at 2 clk_pix cycles from sx/sy/de/hsync/vsync to rgb/de_o/hsync_o/vsync_o.
  - Stage 1 registers the pattern primitives: in-sprite flag, bar index, checker bit, gradient bytes, mode_q.
  - Stage 2 registers the final colour.
- Sync and de outputs pass through two registers, so they stay exactly aligned with rgb.
- Reset (asynchronous, any time, including mid-frame):
  - rgb, de_o, hsync_o, vsync_o, frame, qx, qy, dir_x, dir_y, mode_q and all pipeline registers go to 0 immediately.
  - After release, the first tick advances the sprite to (Q_SPEED, Q_SPEED).
- Sprite position read by the pixel path changes only on the tick cycle, i.e. during vertical blanking, so there is no tearing.
- pause == 1 in the tick cycle: no sprite update, but `frame` still increments.

## Test plan
- **Latency:** release reset, drive a 640×480 raster with mode = 3 → de_o/hsync_o/vsync_o equal inputs delayed by exactly 2 cycles. Pixel at sx=5, sy=7 on frame 0 gives rgb = 0x050700.
- **Sprite bounce:** defaults, mode = 0, run 160 frames → qx = 4 after 1 frame and 608 after 152. dir_x flips at 608. qx = 576 at frame 160. qy hits 448 at frame 112, then decreases.
- **Pause / frame:** pause = 1 for 10 frames → qx/qy unchanged and `frame` advances by 10. Also force frame = 0xFFFF → next tick gives 0.
- **Mode at boundary:** switch mode 0→1 mid-frame → rgb stays in sprite mode until the next tick. Next frame: sx=0 white, sx=80 yellow (FFFF00), sx=639 black.
- **Checker / BPC:** BPC = 4, mode = 2, frame = 0 → sx=32, sy=0 gives rgb = 0xFFF. sx=32, sy=32 gives 0x000. rgb = 0 while de = 0.
- **Async reset mid-frame:** assert rst_n low mid-line → all outputs 0 in the same cycle, without a clock edge. On release, the sprite restarts at (0,0).
